// File: rtl/cla_mp_carry_chain_if.sv
// Byte stream bundle for cla_mp_carry_chain: the adder-side input and the result-side output.
interface cla_mp_carry_chain_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sum;
    logic       in_cout;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       out_carry;
    logic       len_err;
    logic       out_zero;

    modport master (
        output in_valid, in_sum, in_cout, in_last, out_ready,
        input  in_ready, out_valid, out_byte, out_last, out_carry, len_err, out_zero
    );
    modport slave (
        input  in_valid, in_sum, in_cout, in_last, out_ready,
        output in_ready, out_valid, out_byte, out_last, out_carry, len_err, out_zero
    );
endinterface

// File: rtl/cla_mp_carry_chain.sv
// Byte-serial carry fold for multi-byte additions behind an 8-bit CLA, with a 2-entry output FIFO.
// Optional whole-frame zero flag enabled by defining CLA_MP_ZERO_FLAG_EN.
module cla_mp_carry_chain #(
    parameter int MAX_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_mp_carry_chain_if.slave  bus
);
    localparam int BW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    if (MAX_BYTES < 2 || MAX_BYTES > 16) begin : g_bad_param
        $error("cla_mp_carry_chain: MAX_BYTES must be in 2..16");
    end

    typedef struct packed {
        logic [7:0] res;
        logic       last;
        logic       carry;
        logic       lerr;
        logic       zero;
    } entry_t;

    entry_t          fifo [2];
    entry_t          ent;
    entry_t          head;
    logic            wp, rp;
    logic [1:0]      cnt;
    logic            cr;
    logic [BW-1:0]   bcnt;
    logic            push, pop;
    logic            trunc, final_b, carry_nxt, zero_nxt;
    logic [7:0]      result;
`ifdef CLA_MP_ZERO_FLAG_EN
    logic            z;
`endif

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        result    = bus.in_sum + {7'd0, cr};
        // in_cout and the increment carry are mutually exclusive, so OR is exact
        carry_nxt = bus.in_cout | (cr & (&bus.in_sum));
        trunc     = (bcnt == BW'(MAX_BYTES - 1));
        final_b   = bus.in_last | trunc;
`ifdef CLA_MP_ZERO_FLAG_EN
        zero_nxt  = z & (result == 8'd0);
`else
        zero_nxt  = 1'b0;
`endif
        ent.res   = result;
        ent.last  = final_b;
        ent.carry = carry_nxt & final_b;
        ent.lerr  = trunc & ~bus.in_last;
        ent.zero  = zero_nxt & final_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            cnt  <= 2'd0;
            cr   <= 1'b0;
            bcnt <= '0;
`ifdef CLA_MP_ZERO_FLAG_EN
            z    <= 1'b1;
`endif
        end else begin
            if (push) begin
                fifo[wp] <= ent;
                wp       <= ~wp;
                if (final_b) begin
                    cr   <= 1'b0;
                    bcnt <= '0;
`ifdef CLA_MP_ZERO_FLAG_EN
                    z    <= 1'b1;
`endif
                end else begin
                    cr   <= carry_nxt;
                    bcnt <= bcnt + 1'b1;
`ifdef CLA_MP_ZERO_FLAG_EN
                    z    <= zero_nxt;
`endif
                end
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // in_ready depends only on registered occupancy: no pass-through when full
    assign bus.in_ready  = ~cnt[1];
    assign bus.out_valid = (cnt != 2'd0);
    assign head          = fifo[rp];
    assign bus.out_byte  = head.res;
    assign bus.out_last  = head.last;
    assign bus.out_carry = head.carry;
    assign bus.len_err   = head.lerr;
    assign bus.out_zero  = head.zero;
endmodule

// File: tb/tb_cla_mp_carry_chain.sv
// Randomized and directed bench for cla_mp_carry_chain against a wide-integer addition model.
module tb_cla_mp_carry_chain;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_mp_carry_chain_if bus();
    cla_mp_carry_chain #(.MAX_BYTES(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [7:0] s; logic c; logic l; } stim_t;
    typedef struct { logic [7:0] b; logic l; logic c; logic e; logic z; } exp_t;

    stim_t sq[$];
    exp_t  eq[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc;
    logic [7:0] ta [8];
    logic [7:0] tb [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected output comes from whole-operand addition, split into MB-byte frames on truncation.
    task automatic add_frame(input int n, input logic [7:0] a [8], input logic [7:0] b [8]);
        int st;
        st = 0;
        for (int k = 0; k < n; k++) begin
            stim_t s;
            int t;
            t   = int'(a[k]) + int'(b[k]);
            s.s = t[7:0];
            s.c = t[8];
            s.l = (k == n - 1);
            sq.push_back(s);
        end
        while (st < n) begin
            int     len;
            longint av, bv, tv;
            len = (n - st > MB) ? MB : n - st;
            av = 0; bv = 0;
            for (int k = 0; k < len; k++) begin
                av = av | (longint'(a[st+k]) << (8*k));
                bv = bv | (longint'(b[st+k]) << (8*k));
            end
            tv = av + bv;
            for (int k = 0; k < len; k++) begin
                exp_t e;
                logic fin;
                fin = (k == len - 1);
                e.b = 8'(tv >> (8*k));
                e.l = fin;
                e.c = fin ? tv[8*len] : 1'b0;
                e.e = fin && (len == MB) && (st + len != n);
`ifdef CLA_MP_ZERO_FLAG_EN
                e.z = fin && ((tv & ((64'd1 << (8*len)) - 64'd1)) == 64'd0);
`else
                e.z = 1'b0;
`endif
                eq.push_back(e);
            end
            st += len;
        end
    endtask

    task automatic rand_ops(input int n);
        for (int k = 0; k < 8; k++) begin
            ta[k] = (k < n) ? 8'($urandom) : 8'h00;
            tb[k] = (k < n) ? 8'($urandom) : 8'h00;
        end
    endtask

    // One clock: entered and left at negedge, where outputs are sampled.
    task automatic drive_cycle(input logic v, input logic ordy);
        logic push, pop;
        bus.in_valid = v;
        if (v) begin
            bus.in_sum  = sq[0].s;
            bus.in_cout = sq[0].c;
            bus.in_last = sq[0].l;
        end
        bus.out_ready = ordy;
        push = v && bus.in_ready;
        pop  = bus.out_valid && ordy;
        if (pop) begin
            if (eq.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else begin
                check("out_payload",
                      {20'd0, bus.out_byte, bus.out_last, bus.out_carry, bus.len_err, bus.out_zero},
                      {20'd0, eq[0].b, eq[0].l, eq[0].c, eq[0].e, eq[0].z});
                void'(eq.pop_front());
            end
        end
        if (push) void'(sq.pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input bit rnd, input int budget, output int cycles);
        cycles = 0;
        while ((sq.size() != 0 || eq.size() != 0) && cycles < budget) begin
            drive_cycle((sq.size() != 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1),
                        rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            cycles++;
        end
        check("run_drained", 32'(sq.size() + eq.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sum = 8'h00; bus.in_cout = 1'b0; bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_byte",  32'(bus.out_byte),  32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_carry", 32'(bus.out_carry), 32'd0);
        check("rst_len_err",   32'(bus.len_err),   32'd0);
        check("rst_out_zero",  32'(bus.out_zero),  32'd0);

        // 0x00FF + 0x0001, with first-byte latency check
        rand_ops(0);
        ta[0] = 8'hFF; tb[0] = 8'h01;
        add_frame(2, ta, tb);
        drive_cycle(1'b1, 1'b0);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("latency_byte",  32'(bus.out_byte),  32'h00);
        run(1'b0, 50, cyc);

        // 0xFFFF + 0x0001 then carry isolation into a one-byte frame
        rand_ops(0);
        ta[0] = 8'hFF; ta[1] = 8'hFF; tb[0] = 8'h01;
        add_frame(2, ta, tb);
        rand_ops(0);
        ta[0] = 8'h10;
        add_frame(1, ta, tb);
        run(1'b0, 50, cyc);

        // Backpressure
        rand_ops(3);
        add_frame(3, ta, tb);
        drive_cycle(1'b1, 1'b0);
        check("bp_ready_1", 32'(bus.in_ready), 32'd1);
        drive_cycle(1'b1, 1'b0);
        check("bp_ready_2", 32'(bus.in_ready), 32'd0);
        drive_cycle(1'b1, 1'b0);
        check("bp_ready_3", 32'(bus.in_ready), 32'd0);
        check("bp_waiting", 32'(sq.size()), 32'd1);
        check("bp_stable",  32'(bus.out_byte), 32'(eq[0].b));
        drive_cycle(1'b1, 1'b1);
        check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        run(1'b0, 50, cyc);

        // Truncation: 5 bytes without in_last inside MB, then an 8-byte frame
        rand_ops(5);
        add_frame(5, ta, tb);
        run(1'b0, 50, cyc);
        rand_ops(8);
        add_frame(8, ta, tb);
        run(1'b0, 50, cyc);

        // Throughput: 4 bytes with out_ready high take 5 cycles
        rand_ops(4);
        add_frame(4, ta, tb);
        run(1'b0, 50, cyc);
        check("throughput_cycles", 32'(cyc), 32'd5);

        // Reset mid-frame
        sq.push_back('{8'h00, 1'b1, 1'b0});
        eq.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        drive_cycle(1'b1, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        eq.delete();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        rand_ops(0);
        ta[0] = 8'h05;
        add_frame(1, ta, tb);
        run(1'b0, 50, cyc);
        drive_cycle(1'b0, 1'b1);
        check("midrst_no_stale", 32'(bus.out_valid), 32'd0);

        // Random frames with random stalls on both sides
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 8);
            rand_ops(n);
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < n; k++) begin ta[k] = 8'hFF; tb[k] = (k == 0) ? 8'h01 : 8'h00; end
            add_frame(n, ta, tb);
        end
        run(1'b1, 5000, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
